link_uart_rx: RTL and testbench



---
 rtl/link_uart_pkg.sv | 21 ++
 rtl/link_rx_fifo.sv | 72 +++++++
 rtl/link_uart_rx.sv | 143 ++++++++++++++
 tb/tb_link_uart_rx.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/link_uart_pkg.sv
// Shared definitions for the link-port UART receive path:
// FSM encodings, 8N1 frame constants and default baud divisor.
package link_uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_WAIT_HIGH
   } rx_state_e;

   localparam int   DATA_BITS  = 8;
   localparam logic IDLE_LEVEL = 1'b1;

   localparam int GB_CLK_HZ = 4194304;
   localparam int UART_BAUD = 115200;
   // Integer division truncates 36.4 down to 36.
   localparam int DEF_CLKS_PER_BIT = GB_CLK_HZ / UART_BAUD;

endpackage

// File: rtl/link_rx_fifo.sv
// First-word-fall-through byte FIFO between the UART receiver
// and the link/SB register logic.
module link_rx_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         din_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         dout_o,
   output logic                     empty_o,
   output logic                     full_o,
   output logic [$clog2(DEPTH):0]   level_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr_q, wptr_d;
   logic [AW-1:0]    rptr_q, rptr_d;
   logic [AW:0]      count_q, count_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);

   always_comb begin
      wptr_d  = do_push ? wptr_q + 1'b1 : wptr_q;
      rptr_d  = do_pop ? rptr_q + 1'b1 : rptr_q;
      count_d = count_q;
      unique case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      // Head is registered; a write into an empty slot bypasses mem.
      dout_d = dout_q;
      if (count_d != '0) begin
         if (do_push && (wptr_q == rptr_d))
            dout_d = din_i;
         else
            dout_d = mem[rptr_d];
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem[wptr_q] <= din_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         dout_q  <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         dout_q  <= dout_d;
      end
   end

   assign dout_o  = dout_q;
   assign level_o = count_q;

endmodule

// File: rtl/link_uart_rx.sv
// 8N1 UART receiver for the link port: synchroniser, baud
// timing and frame FSM feeding a small FWFT FIFO.
module link_uart_rx
   import link_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                          clockgb,
   input  logic                          resetn,
   input  logic                          UART_RX,
   output logic [7:0]                    rx_data,
   output logic                          rx_valid,
   input  logic                          rx_ready,
   output logic                          rx_irq,
   output logic                          frame_err,
   output logic                          overrun,
   input  logic                          err_clear,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int BW   = $clog2(CLKS_PER_BIT);
   localparam int BITW = $clog2(DATA_BITS);
   localparam logic [BW-1:0]   BAUD_MAX  = BW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0]   BAUD_HALF = BW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [BITW-1:0] BIT_LAST  = BITW'(DATA_BITS - 1);

   rx_state_e       state_q, state_d;
   logic            sync_q, rxs_q, rxs_prev_q;
   logic [BW-1:0]   baud_q, baud_d;
   logic [BITW-1:0] bit_q, bit_d;
   logic [7:0]      shift_q, shift_d;
   logic            ferr_q, ferr_d;
   logic            ovr_q, ovr_d;
   logic            push, pop, full, empty;
   logic            set_ferr, set_ovr;

   assign rx_valid = ~empty;
   assign pop      = rx_valid & rx_ready;

   always_comb begin
      state_d  = state_q;
      baud_d   = baud_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      push     = 1'b0;
      set_ferr = 1'b0;
      set_ovr  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (rxs_prev_q && !rxs_q) begin
               state_d = ST_START;
               baud_d  = '0;
            end
         end
         ST_START: begin
            if (baud_q == BAUD_HALF) begin
               baud_d  = '0;
               bit_d   = '0;
               state_d = rxs_q ? ST_IDLE : ST_DATA;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         ST_DATA: begin
            if (baud_q == BAUD_MAX) begin
               baud_d  = '0;
               shift_d = {rxs_q, shift_q[7:1]};
               bit_d   = bit_q + 1'b1;
               if (bit_q == BIT_LAST) state_d = ST_STOP;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         ST_STOP: begin
            if (baud_q == BAUD_MAX) begin
               baud_d = '0;
               if (rxs_q == IDLE_LEVEL) begin
                  state_d = ST_IDLE;
                  if (!full || pop) push = 1'b1;
                  else              set_ovr = 1'b1;
               end else begin
                  set_ferr = 1'b1;
                  state_d  = ST_WAIT_HIGH;
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         ST_WAIT_HIGH: begin
            // Hold off until the line idles so a break is one error.
            if (rxs_q == IDLE_LEVEL) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      ferr_d = set_ferr | (ferr_q & ~err_clear);
      ovr_d  = set_ovr | (ovr_q & ~err_clear);
   end

   always_ff @(posedge clockgb or negedge resetn) begin
      if (!resetn) begin
         state_q    <= ST_IDLE;
         sync_q     <= 1'b1;
         rxs_q      <= 1'b1;
         rxs_prev_q <= 1'b1;
         baud_q     <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         ferr_q     <= 1'b0;
         ovr_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         sync_q     <= UART_RX;
         rxs_q      <= sync_q;
         rxs_prev_q <= rxs_q;
         baud_q     <= baud_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         ferr_q     <= ferr_d;
         ovr_q      <= ovr_d;
      end
   end

   link_rx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk_i   (clockgb),
      .rst_ni  (resetn),
      .push_i  (push),
      .din_i   (shift_q),
      .pop_i   (pop),
      .dout_o  (rx_data),
      .empty_o (empty),
      .full_o  (full),
      .level_o (fifo_level)
   );

   assign rx_irq    = push;
   assign frame_err = ferr_q;
   assign overrun   = ovr_q;

endmodule

// File: tb/tb_link_uart_rx.sv
// Scenario bench for link_uart_rx with a byte scoreboard queue.
// Frames are driven with 8 clocks per bit, FIFO depth 4.
module tb_link_uart_rx;

   localparam int CPB   = 8;
   localparam int DEPTH = 4;

   logic       clockgb = 1'b0;
   logic       resetn = 1'b0;
   logic       UART_RX = 1'b1;
   logic       rx_ready = 1'b0;
   logic       err_clear = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid, rx_irq, frame_err, overrun;
   logic [2:0] fifo_level;

   int n_checks = 0;
   int n_pass = 0;
   int cyc = 0;
   int irq_cnt = 0;
   int irq_long = 0;
   int last_irq_cyc = -1;
   int rise_cyc = -1;
   logic irq_prev = 1'b0;
   logic valid_prev = 1'b0;
   logic [7:0] exp_q[$];

   always #5 clockgb = ~clockgb;

   link_uart_rx #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clockgb    (clockgb),
      .resetn     (resetn),
      .UART_RX    (UART_RX),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .rx_irq     (rx_irq),
      .frame_err  (frame_err),
      .overrun    (overrun),
      .err_clear  (err_clear),
      .fifo_level (fifo_level)
   );

   always @(posedge clockgb) cyc++;

   always @(negedge clockgb) begin
      if (rx_irq) begin
         irq_cnt++;
         last_irq_cyc = cyc;
         if (irq_prev) irq_long++;
      end
      if (rx_valid && !valid_prev) rise_cyc = cyc;
      irq_prev   = rx_irq;
      valid_prev = rx_valid;
   end

   initial begin
      #500us;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "timeout");
   end

   task automatic send_byte(input logic [7:0] b, input logic stop,
                            input bit pop_at_stop, output int c0);
      logic [7:0] e;
      @(posedge clockgb);
      #1;
      c0 = cyc;
      UART_RX = 1'b0;
      repeat (CPB) @(posedge clockgb);
      for (int i = 0; i < 8; i++) begin
         #1 UART_RX = b[i];
         repeat (CPB) @(posedge clockgb);
      end
      #1 UART_RX = stop;
      for (int k = 1; k <= CPB; k++) begin
         @(posedge clockgb);
         #1;
         if (pop_at_stop && k == CPB - 2) begin
            rx_ready = 1'b1;
            n_checks++;
            if (exp_q.size() == 0)
               $display("FAIL stop_pop_data got %h required none", rx_data);
            else begin
               e = exp_q.pop_front();
               if (rx_data !== e)
                  $display("FAIL stop_pop_data got %h required %h", rx_data, e);
               else n_pass++;
            end
         end
         if (pop_at_stop && k == CPB - 1) rx_ready = 1'b0;
      end
   endtask

   task automatic pop_all(input string tag);
      logic [7:0] e;
      bit done;
      done = 1'b0;
      @(posedge clockgb);
      #1 rx_ready = 1'b1;
      for (int i = 0; i < 4 * DEPTH + 4 && !done; i++) begin
         @(negedge clockgb);
         if (!rx_valid) done = 1'b1;
         else begin
            n_checks++;
            if (exp_q.size() == 0)
               $display("FAIL %s_data got %h required none", tag, rx_data);
            else begin
               e = exp_q.pop_front();
               if (rx_data !== e)
                  $display("FAIL %s_data got %h required %h", tag, rx_data, e);
               else n_pass++;
            end
         end
      end
      rx_ready = 1'b0;
      n_checks++;
      if (!done || exp_q.size() != 0)
         $display("FAIL %s_drain got done=%0d left=%0d required 1/0",
                  tag, done, exp_q.size());
      else n_pass++;
   endtask

   task automatic check_idle_outputs(input string tag);
      n_checks++;
      if ({rx_data, rx_valid, rx_irq, frame_err, overrun, fifo_level} !== 15'd0)
         $display("FAIL %s got data=%h v=%b irq=%b fe=%b ov=%b lvl=%0d required all 0",
                  tag, rx_data, rx_valid, rx_irq, frame_err, overrun, fifo_level);
      else n_pass++;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      repeat (3) @(negedge clockgb);
      check_idle_outputs("reset_hold");
      @(posedge clockgb);
      #1 resetn = 1'b1;
      repeat (4) @(negedge clockgb);
      check_idle_outputs("reset_release");
   endtask

   task automatic test_frame_a5();
      int c0, irq0;
      irq0 = irq_cnt;
      exp_q.push_back(8'hA5);
      send_byte(8'hA5, 1'b1, 1'b0, c0);
      repeat (2) @(posedge clockgb);
      #1;
      n_checks++;
      if (last_irq_cyc !== c0 + 78)
         $display("FAIL a5_irq_cycle got %0d required %0d", last_irq_cyc, c0 + 78);
      else n_pass++;
      n_checks++;
      if (rise_cyc !== last_irq_cyc + 1)
         $display("FAIL a5_valid_latency got %0d required %0d", rise_cyc, last_irq_cyc + 1);
      else n_pass++;
      n_checks++;
      if (irq_cnt - irq0 !== 1 || irq_long !== 0)
         $display("FAIL a5_irq_pulses got %0d long=%0d required 1/0", irq_cnt - irq0, irq_long);
      else n_pass++;
      n_checks++;
      if (rx_valid !== 1'b1 || rx_data !== 8'hA5 || fifo_level !== 3'd1)
         $display("FAIL a5_head got v=%b d=%h lvl=%0d required 1/a5/1", rx_valid, rx_data, fifo_level);
      else n_pass++;
      pop_all("a5");
   endtask

   task automatic test_glitch();
      int irq0;
      irq0 = irq_cnt;
      @(posedge clockgb);
      #1 UART_RX = 1'b0;
      repeat (3) @(posedge clockgb);
      #1 UART_RX = 1'b1;
      repeat (30) @(posedge clockgb);
      #1;
      n_checks++;
      if (irq_cnt != irq0 || fifo_level !== 3'd0 || frame_err !== 1'b0 || overrun !== 1'b0)
         $display("FAIL glitch got irq=%0d lvl=%0d fe=%b ov=%b required 0/0/0/0",
                  irq_cnt - irq0, fifo_level, frame_err, overrun);
      else n_pass++;
   endtask

   task automatic test_frame_err();
      int c0, irq0;
      irq0 = irq_cnt;
      send_byte(8'h3C, 1'b0, 1'b0, c0);
      repeat (40 * CPB) @(posedge clockgb);
      #1 UART_RX = 1'b1;
      repeat (4 * CPB) @(posedge clockgb);
      #1;
      n_checks++;
      if (frame_err !== 1'b1 || overrun !== 1'b0)
         $display("FAIL ferr_flag got fe=%b ov=%b required 1/0", frame_err, overrun);
      else n_pass++;
      n_checks++;
      if (fifo_level !== 3'd0 || irq_cnt != irq0)
         $display("FAIL ferr_push got lvl=%0d irq=%0d required 0/0", fifo_level, irq_cnt - irq0);
      else n_pass++;
      err_clear = 1'b1;
      @(posedge clockgb);
      #1 err_clear = 1'b0;
      n_checks++;
      if (frame_err !== 1'b0)
         $display("FAIL ferr_clear got %b required 0", frame_err);
      else n_pass++;
   endtask

   task automatic test_overrun();
      int c0, irq0;
      logic [7:0] b;
      irq0 = irq_cnt;
      for (int i = 1; i <= 5; i++) begin
         b = 8'(i);
         if (i <= DEPTH) exp_q.push_back(b);
         send_byte(b, 1'b1, 1'b0, c0);
      end
      repeat (2) @(posedge clockgb);
      #1;
      n_checks++;
      if (fifo_level !== 3'd4 || overrun !== 1'b1)
         $display("FAIL ovr_state got lvl=%0d ov=%b required 4/1", fifo_level, overrun);
      else n_pass++;
      n_checks++;
      if (irq_cnt - irq0 != 4 || rx_data !== 8'h01)
         $display("FAIL ovr_irq got irq=%0d head=%h required 4/01", irq_cnt - irq0, rx_data);
      else n_pass++;
      pop_all("ovr");
      n_checks++;
      if (rx_valid !== 1'b0 || overrun !== 1'b1)
         $display("FAIL ovr_after_drain got v=%b ov=%b required 0/1", rx_valid, overrun);
      else n_pass++;
      err_clear = 1'b1;
      @(posedge clockgb);
      #1 err_clear = 1'b0;
      n_checks++;
      if (overrun !== 1'b0)
         $display("FAIL ovr_clear got %b required 0", overrun);
      else n_pass++;
   endtask

   task automatic test_pop_at_stop();
      int c0, irq0;
      logic [7:0] b;
      for (int i = 0; i < DEPTH; i++) begin
         b = 8'h10 + 8'(i);
         exp_q.push_back(b);
         send_byte(b, 1'b1, 1'b0, c0);
      end
      irq0 = irq_cnt;
      exp_q.push_back(8'h77);
      send_byte(8'h77, 1'b1, 1'b1, c0);
      repeat (2) @(posedge clockgb);
      #1;
      n_checks++;
      if (overrun !== 1'b0 || fifo_level !== 3'd4 || irq_cnt - irq0 != 1)
         $display("FAIL popstop got ov=%b lvl=%0d irq=%0d required 0/4/1",
                  overrun, fifo_level, irq_cnt - irq0);
      else n_pass++;
      pop_all("popstop");
   endtask

   task automatic test_reset_mid();
      int c0, irq0;
      @(posedge clockgb);
      #1 UART_RX = 1'b0;
      repeat (CPB) @(posedge clockgb);
      #1 UART_RX = 1'b1;
      repeat (20) @(posedge clockgb);
      #1 resetn = 1'b0;
      #2;
      check_idle_outputs("rst_mid_async");
      repeat (3) @(posedge clockgb);
      #1 resetn = 1'b1;
      repeat (10 * CPB) @(posedge clockgb);
      #1;
      check_idle_outputs("rst_mid_after");
      irq0 = irq_cnt;
      exp_q.push_back(8'h42);
      send_byte(8'h42, 1'b1, 1'b0, c0);
      repeat (2) @(posedge clockgb);
      #1;
      n_checks++;
      if (irq_cnt - irq0 != 1 || fifo_level !== 3'd1 || frame_err !== 1'b0)
         $display("FAIL rst_mid_42 got irq=%0d lvl=%0d fe=%b required 1/1/0",
                  irq_cnt - irq0, fifo_level, frame_err);
      else n_pass++;
      pop_all("rst_mid");
   endtask

   initial begin
      test_reset();
      test_frame_a5();
      test_glitch();
      test_frame_err();
      test_overrun();
      test_pop_at_stop();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
